// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform phase generator.
// Optional dither (macro WAVE_DITHER_EN) uses the LFSR constants below.
package wave_pkg;

  localparam int unsigned ACC_W   = 24;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned SEL_MAX = 10;
  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned DITH_W  = ACC_W - ADDR_W;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, RUN, PEND} phase_state_t;

  typedef struct packed {
    logic [ACC_W-1:0] fcw;
    logic [SEL_W-1:0] sel;
  } phase_cfg_t;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel);
    return (sel > SEL_W'(SEL_MAX)) ? SEL_W'(SEL_MAX) : sel;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/wave_tick_div.sv
// Sample-tick divider: ticks once every (div+1) enabled cycles, div sampled live.
module wave_tick_div
  import wave_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  // >= so a shrinking div never strands the counter above the new terminal
  assign tick_c = en && (cnt >= div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/wave_phase_gen.sv
// NCO phase accumulator producing table address and duty select per sample tick;
// config changes are double-buffered to period boundaries. Macro WAVE_DITHER_EN adds LFSR address dither.
module wave_phase_gen
  import wave_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [ACC_W-1:0]  i_fcw,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_load,
  output logic [ADDR_W-1:0] o_addr,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_valid,
  output logic              o_wrap,
  output logic              o_pend
);

  phase_state_t      state, state_nxt;
  phase_cfg_t        cfg_act, cfg_shd, cfg_in_c;
  logic [ACC_W-1:0]  acc;
  logic              wrap_flag;
  logic              run_c, tick_c, carry_c, apply_c;
  logic [ACC_W:0]    sum_c;
  logic [ADDR_W-1:0] addr_c;

  assign run_c    = (state != IDLE) && i_en;
  assign cfg_in_c = phase_cfg_t'{fcw: i_fcw, sel: clamp_sel(i_sel)};
  assign sum_c    = {1'b0, acc} + {1'b0, cfg_act.fcw};
  assign carry_c  = sum_c[ACC_W];
  // a zero increment never carries, so pending config lands on the next tick instead
  assign apply_c  = (state == PEND) && tick_c && (carry_c || (cfg_act.fcw == '0));

  wave_tick_div u_tick_div (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .en     (run_c),
    .div    (i_div),
    .tick_c (tick_c)
  );

`ifdef WAVE_DITHER_EN
  logic [LFSR_W-1:0] lfsr;
  logic [ACC_W:0]    dsum_c;
  logic [ACC_W-1:0]  dacc_c;

  assign dsum_c = {1'b0, acc} + (ACC_W+1)'(lfsr[DITH_W-1:0]);
  assign dacc_c = dsum_c[ACC_W] ? '1 : dsum_c[ACC_W-1:0];
  assign addr_c = dacc_c[ACC_W-1 -: ADDR_W];

  // restarts from the seed whenever the generator is (or is about to be) idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (!run_c) begin
      lfsr <= LFSR_SEED;
    end else if (tick_c) begin
      lfsr <= lfsr_next(lfsr);
    end
  end
`else
  assign addr_c = acc[ACC_W-1 -: ADDR_W];
`endif

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; a load coinciding with an apply keeps us pending for the new shadows
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_en) state_nxt = RUN;
      RUN: begin
        if (!i_en)       state_nxt = IDLE;
        else if (i_load) state_nxt = PEND;
      end
      PEND: begin
        if (!i_en)                   state_nxt = IDLE;
        else if (apply_c && !i_load) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, config registers and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc       <= '0;
      wrap_flag <= 1'b0;
      cfg_act   <= '0;
      cfg_shd   <= '0;
      o_addr    <= '0;
      o_sel     <= '0;
      o_valid   <= 1'b0;
      o_wrap    <= 1'b0;
      o_pend    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
      o_pend  <= (state_nxt == PEND);
      if (state == IDLE) begin
        acc       <= '0;
        wrap_flag <= 1'b1;
        if (i_load) cfg_act <= cfg_in_c;
      end else if (!i_en) begin
        acc       <= '0;
        o_addr    <= '0;
        wrap_flag <= 1'b1;
      end else begin
        if (tick_c) begin
          o_addr    <= addr_c;
          o_sel     <= cfg_act.sel;
          acc       <= sum_c[ACC_W-1:0];
          o_valid   <= 1'b1;
          o_wrap    <= wrap_flag;
          wrap_flag <= carry_c;
        end
        if (apply_c) cfg_act <= cfg_shd;
        if (i_load)  cfg_shd <= cfg_in_c;
      end
    end
  end

endmodule

// File: tb/tb_wave_phase_gen.sv
// Directed bench for wave_phase_gen (default build): vector table plus multi-cycle sequences.
module tb_wave_phase_gen;
  import wave_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [ACC_W-1:0]  fcw;
  logic [DIV_W-1:0]  div;
  logic [SEL_W-1:0]  sel;
  logic              load;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  osel;
  logic              valid, wrap, pend;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        en;
    logic        load;
    logic [23:0] fcw;
    logic [15:0] div;
    logic [3:0]  sel;
    int          v;
    int          a;
    int          w;
    int          s;
    int          p;
  } vec_t;

  vec_t tbl[18];

  wave_phase_gen dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_fcw   (fcw),
    .i_div   (div),
    .i_sel   (sel),
    .i_load  (load),
    .o_addr  (addr),
    .o_sel   (osel),
    .o_valid (valid),
    .o_wrap  (wrap),
    .o_pend  (pend)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic l, input logic [23:0] f,
                              input logic [15:0] d, input logic [3:0] s,
                              input int ev, input int ea, input int ew, input int es, input int ep);
    vec_t r;
    r.en = e; r.load = l; r.fcw = f; r.div = d; r.sel = s;
    r.v = ev; r.a = ea; r.w = ew; r.s = es; r.p = ep;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input int v, input int a, input int w, input int s, input int p);
    chk({nm, ".valid"}, int'(valid), v);
    chk({nm, ".addr"},  int'(addr),  a);
    chk({nm, ".wrap"},  int'(wrap),  w);
    chk({nm, ".sel"},   int'(osel),  s);
    chk({nm, ".pend"},  int'(pend),  p);
  endtask

  task automatic step_run(input string nm, input int a, input int w, input int s, input int p);
    cyc();
    chk_out(nm, 1, a, w, s, p);
  endtask

  initial begin
    //                en    ld    fcw        div    sel   v  a  w  s  p
    tbl[0]  = mk(1'b0, 1'b1, 24'h004000, 16'd0, 4'd3, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1'b1, 1'b0, 24'h004000, 16'd0, 4'd3, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1'b1, 1'b0, 24'h004000, 16'd0, 4'd3, 1, 0, 1, 3, 0);
    tbl[3]  = mk(1'b1, 1'b0, 24'h004000, 16'd0, 4'd3, 1, 1, 0, 3, 0);
    tbl[4]  = mk(1'b1, 1'b0, 24'h004000, 16'd0, 4'd3, 1, 2, 0, 3, 0);
    tbl[5]  = mk(1'b1, 1'b0, 24'h004000, 16'd3, 4'd3, 0, 2, 0, 3, 0);
    tbl[6]  = mk(1'b1, 1'b0, 24'h004000, 16'd3, 4'd3, 0, 2, 0, 3, 0);
    tbl[7]  = mk(1'b1, 1'b0, 24'h004000, 16'd3, 4'd3, 0, 2, 0, 3, 0);
    tbl[8]  = mk(1'b1, 1'b0, 24'h004000, 16'd3, 4'd3, 1, 3, 0, 3, 0);
    tbl[9]  = mk(1'b1, 1'b0, 24'h004000, 16'd3, 4'd3, 0, 3, 0, 3, 0);
    tbl[10] = mk(1'b1, 1'b0, 24'h004000, 16'd1, 4'd3, 1, 4, 0, 3, 0);
    tbl[11] = mk(1'b1, 1'b0, 24'h004000, 16'd1, 4'd3, 0, 4, 0, 3, 0);
    tbl[12] = mk(1'b1, 1'b0, 24'h004000, 16'd1, 4'd3, 1, 5, 0, 3, 0);
    tbl[13] = mk(1'b1, 1'b0, 24'h004000, 16'd3, 4'd3, 0, 5, 0, 3, 0);
    tbl[14] = mk(1'b1, 1'b0, 24'h004000, 16'd3, 4'd3, 0, 5, 0, 3, 0);
    tbl[15] = mk(1'b1, 1'b0, 24'h004000, 16'd1, 4'd3, 1, 6, 0, 3, 0);
    tbl[16] = mk(1'b1, 1'b0, 24'h004000, 16'd0, 4'd3, 1, 7, 0, 3, 0);
    tbl[17] = mk(1'b1, 1'b0, 24'h004000, 16'd0, 4'd3, 1, 8, 0, 3, 0);

    rst_n = 1'b0; en = 1'b0; fcw = '0; div = '0; sel = '0; load = 1'b0;
    cyc();
    chk_out("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // idle load, enable, divider changes
    for (int i = 0; i < 18; i++) begin
      en = tbl[i].en; load = tbl[i].load; fcw = tbl[i].fcw; div = tbl[i].div; sel = tbl[i].sel;
      cyc();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].a, tbl[i].w, tbl[i].s, tbl[i].p);
    end

    // full period sweep at step 1, through the wrap, up to addr 100
    for (int k = 0; k < 1116; k++) begin
      int a;
      a = (9 + k) % 1024;
      step_run("sweep", a, (a == 0) ? 1 : 0, 3, 0);
    end

    // buffered frequency/duty change waits for the period boundary
    load = 1'b1; fcw = 24'h008000; sel = 4'd5;
    step_run("ld_fcw", 101, 0, 3, 1);
    load = 1'b0;
    for (int a = 102; a <= 1022; a++) step_run("pend1", a, 0, 3, 1);
    step_run("apply1", 1023, 0, 3, 0);
    step_run("new_wrap", 0, 1, 5, 0);
    for (int a = 2; a <= 6; a += 2) step_run("step2", a, 0, 5, 0);

    // duty clamp, zero increment
    load = 1'b1; fcw = 24'h000000; sel = 4'd13;
    step_run("ld_zero", 8, 0, 5, 1);
    load = 1'b0;
    for (int a = 10; a <= 1020; a += 2) step_run("pend2", a, 0, 5, 1);
    step_run("apply2", 1022, 0, 5, 0);
    step_run("clamp_wrap", 0, 1, 10, 0);
    step_run("zero_hold0", 0, 0, 10, 0);
    step_run("zero_hold1", 0, 0, 10, 0);

    // pending load with zero increment lands on the very next tick
    load = 1'b1; fcw = 24'h004000; sel = 4'd2;
    step_run("ld_z2", 0, 0, 10, 1);
    load = 1'b0;
    step_run("apply_z", 0, 0, 10, 0);
    step_run("after_z0", 0, 0, 2, 0);
    step_run("after_z1", 1, 0, 2, 0);
    for (int a = 2; a <= 500; a++) step_run("run500", a, 0, 2, 0);

    // enable drop and restart
    en = 1'b0;
    cyc();
    chk_out("en_off0", 0, 0, 0, 2, 0);
    cyc();
    chk_out("en_off1", 0, 0, 0, 2, 0);
    en = 1'b1;
    cyc();
    chk_out("en_on0", 0, 0, 0, 2, 0);
    step_run("en_first", 0, 1, 2, 0);
    step_run("en_second", 1, 0, 2, 0);

    // async reset mid-cycle while pending
    load = 1'b1; fcw = 24'h008000; sel = 4'd7;
    step_run("ld_rst", 2, 0, 2, 1);
    load = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 0, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk_out("rst_idle", 0, 0, 0, 0, 0);
    step_run("rst_first", 0, 1, 0, 0);
    step_run("rst_fcw0", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
